imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, registered immediate generator for the decode stage. It decodes the 26-bit immediate field into an XLEN-bit operand in formats B, C, D and E, with selectable sign or zero extension. It adds a prefix mechanism that builds a full 32-bit constant from two consecutive instructions. It has a one-entry valid/ready output register, so decode stalls and flushes are handled locally.

## Interface
Parameters:
- XLEN, 32, output operand width; must be ≥ 32
- E_SHIFT, 2, left shift applied to the format-E immediate (word alignment)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- in_valid  in  1  upstream has an immediate to decode
- in_ready  out  1  block accepts input this cycle
- imm_in  in  26  raw immediate field, instruction bits [25:0]
- imm_src  in  3  [2:1] format (00 B, 01 C, 10 E, 11 D); [0] 0 = sign-extend, 1 = zero-extend
- prefix  in  1  accepted item is an upper-half prefix, not an operand
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  imm_out holds a valid operand
- out_ready  in  1  downstream consumes the operand
- imm_out  out  XLEN  decoded operand
- out_prefixed  out  1  imm_out was built from a prefix + base pair

## Operation
- Field extraction:
  - B = imm_in[25:10] (16 b)
  - C = {imm_in[25:15], imm_in[10:6]} (16 b)
  - D = imm_in[25:5] (21 b)
  - E = C << E_SHIFT (16+E_SHIFT b)
- Extension bit s = imm_src[0] ? 0 : imm_in[25]. The field is extended with s to XLEN.
- Accept condition: in_valid && in_ready.
- Accepted item with prefix=1:
  - Loads pfx_reg ← C field and sets pfx_valid ← 1.
  - pfx_sext ← !imm_src[0].
  - Produces no output; the output register is untouched.
  - A second prefix before a base overwrites pfx_reg.
- Accepted item with prefix=0 and pfx_valid=0: the output register loads the extended field, out_prefixed ← 0.
- Accepted item with prefix=0 and pfx_valid=1:
  - The output register loads {pfx_reg, base[15:0]}, where base is the extended field selected by imm_src.
  - Bits above 31 are filled with pfx_reg[15] if pfx_sext, else 0.
  - out_prefixed ← 1 and pfx_valid ← 0 in the same edge.
- in_ready = !flush && (!out_valid || out_ready). This is combinational, with no dependency on in_valid.
- out_valid:
  - Set on accepting a base item.
  - Cleared when out_valid && out_ready and no new base item is accepted.
  - Stays set if a base item is accepted in the same cycle as the consume.
- While out_valid && !out_ready, imm_out and out_prefixed hold stable.
- flush=1 at an edge clears out_valid, out_prefixed and pfx_valid. imm_out keeps its value (don't-care). No input is accepted during flush.
- Reset (async assert, any time): out_valid=0, imm_out=0, out_prefixed=0, pfx_valid=0, pfx_reg=0, pfx_sext=0. in_ready reads 1 after reset while flush=0.

## Timing
- Latency: base accepted at edge N appears on imm_out with out_valid=1 after edge N. Latency is 1 cycle.
- Prefix + base: the operand appears 1 cycle after the base is accepted. Cycles between prefix and base, and intervening stalls, do not clear pfx_valid; only base, flush or reset do.
- Throughput: 1 operand per cycle when out_ready is held at 1.
- Simultaneous consume and accept: the new value replaces the old one at the same edge, with no bubble.
- Simultaneous flush and valid input: flush wins and the input is not accepted (in_ready=0).
- Reset deassertion mid-stall: the held operand is lost, and out_valid=0 on the first cycle after reset.

## Test plan
- Formats, XLEN=32, out_ready=1:
  - imm_in=26'h2000000, src=000 → 32'hFFFF8000
  - src=001 → 32'h00008000
  - imm_in=26'h3FFFFC0, src=100 → 32'hFFFFFFFC
  - imm_in=26'h0000020, src=110 → 32'h00000001
  - Each appears 1 cycle after accept.
- Prefix pair: prefix=1, imm_in=26'h0488500, src=011, then base imm_in=26'h3FFFC00, src=001 → one output 32'h1234FFFF with out_prefixed=1. The prefix cycle produces no out_valid.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, imm_out stable. When out_ready rises, the next item follows with no bubble. Every item is output exactly once and in order.
- Flush: prefix accepted, then flush=1 with a valid base input → out_valid=0, base dropped. A following base imm_in=26'h0000400, src=001 yields 32'h00000001 with out_prefixed=0.
- XLEN=64: prefix C=16'h8000, src=010, then base B=16'h0001 → 64'hFFFFFFFF80000001. The same pair with prefix src=011 → 64'h0000000080000001.
- Async reset asserted mid-stall with out_valid=1 → all outputs 0 immediately, without a clock edge. After release, in_ready=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage: extracts format B/C/D/E
// fields, extends them to XLEN, pairs an optional upper-half prefix with the next base.
module imm_gen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned E_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [25:0]     imm_in,
  input  logic [2:0]      imm_src,
  input  logic            prefix,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            out_prefixed
);

  localparam int unsigned E_W = 16 + E_SHIFT;

  typedef enum logic [1:0] {
    FMT_B = 2'b00,
    FMT_C = 2'b01,
    FMT_E = 2'b10,
    FMT_D = 2'b11
  } fmt_e;

  logic [15:0]     fld_b;
  logic [15:0]     fld_c;
  logic [20:0]     fld_d;
  logic [E_W-1:0]  fld_e;
  logic            ext_bit;
  fmt_e            fmt;
  logic [XLEN-1:0] base_ext;
  logic [XLEN-1:0] pfx_word;

  logic            accept;
  logic            acc_pfx;
  logic            acc_base;

  logic            out_valid_q,    out_valid_d;
  logic [XLEN-1:0] imm_q,          imm_d;
  logic            out_prefixed_q, out_prefixed_d;
  logic            pfx_valid_q,    pfx_valid_d;
  logic [15:0]     pfx_q,          pfx_d;
  logic            pfx_sext_q,     pfx_sext_d;

  assign fld_b   = imm_in[25:10];
  assign fld_c   = {imm_in[25:15], imm_in[10:6]};
  assign fld_d   = imm_in[25:5];
  assign fld_e   = E_W'(fld_c) << E_SHIFT;
  assign ext_bit = imm_src[0] ? 1'b0 : imm_in[25];
  assign fmt     = fmt_e'(imm_src[2:1]);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case/if leaves it unassigned and no latch is inferred.
  always_comb begin
    base_ext = {XLEN{ext_bit}};
    unique case (fmt)
      FMT_B: base_ext[15:0]    = fld_b;
      FMT_C: base_ext[15:0]    = fld_c;
      FMT_E: base_ext[E_W-1:0] = fld_e;
      FMT_D: base_ext[20:0]    = fld_d;
    endcase
  end

  // Prefix supplies bits [31:16]; above that the prefix's own extension applies.
  always_comb begin
    pfx_word       = {XLEN{pfx_sext_q & pfx_q[15]}};
    pfx_word[31:0] = {pfx_q, base_ext[15:0]};
  end

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_pfx  = accept && prefix;
  assign acc_base = accept && !prefix;

  always_comb begin
    out_valid_d    = out_valid_q;
    imm_d          = imm_q;
    out_prefixed_d = out_prefixed_q;
    pfx_valid_d    = pfx_valid_q;
    pfx_d          = pfx_q;
    pfx_sext_d     = pfx_sext_q;

    if (flush) begin
      out_valid_d    = 1'b0;
      out_prefixed_d = 1'b0;
      pfx_valid_d    = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (acc_pfx) begin
        pfx_d       = fld_c;
        pfx_valid_d = 1'b1;
        pfx_sext_d  = !imm_src[0];
      end

      // A base accepted alongside a consume overrides the clear above: no bubble.
      if (acc_base) begin
        out_valid_d    = 1'b1;
        imm_d          = pfx_valid_q ? pfx_word : base_ext;
        out_prefixed_d = pfx_valid_q;
        pfx_valid_d    = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      imm_q          <= '0;
      out_prefixed_q <= 1'b0;
      pfx_valid_q    <= 1'b0;
      pfx_q          <= '0;
      pfx_sext_q     <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      imm_q          <= imm_d;
      out_prefixed_q <= out_prefixed_d;
      pfx_valid_q    <= pfx_valid_d;
      pfx_q          <= pfx_d;
      pfx_sext_q     <= pfx_sext_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign imm_out      = imm_q;
  assign out_prefixed = out_prefixed_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared cycle by cycle against an arithmetic reference model.
module tb_imm_gen_pipe;

  localparam int unsigned TB_E_SHIFT = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [25:0] imm_in;
  logic [2:0]  imm_src;
  logic        prefix;
  logic        flush;
  logic        out_ready;

  logic        rdy32, rdy64;
  logic        ov32, ov64;
  logic        op32, op64;
  logic [31:0] io32;
  logic [63:0] io64;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic        m_valid;
  logic        m_pfx;
  logic [63:0] m_val;
  logic        pv;
  logic [15:0] preg;
  logic        psext;

  imm_gen_pipe #(.XLEN(32), .E_SHIFT(TB_E_SHIFT)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .imm_in(imm_in), .imm_src(imm_src), .prefix(prefix), .flush(flush),
    .out_valid(ov32), .out_ready(out_ready), .imm_out(io32), .out_prefixed(op32)
  );

  imm_gen_pipe #(.XLEN(64), .E_SHIFT(TB_E_SHIFT)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .imm_in(imm_in), .imm_src(imm_src), .prefix(prefix), .flush(flush),
    .out_valid(ov64), .out_ready(out_ready), .imm_out(io64), .out_prefixed(op64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] c_field(input logic [25:0] imm);
    logic [63:0] x;
    x = 64'(imm);
    return ((x >> 15) << 5) | ((x >> 6) & 64'd31);
  endfunction

  function automatic logic [63:0] ref_ext(input logic [25:0] imm, input logic [2:0] src);
    logic [63:0] x, f;
    int w;
    x = 64'(imm);
    case (src[2:1])
      2'b00:   begin f = x >> 10;                    w = 16; end
      2'b01:   begin f = c_field(imm);               w = 16; end
      2'b10:   begin f = c_field(imm) << TB_E_SHIFT; w = 16 + TB_E_SHIFT; end
      default: begin f = x >> 5;                     w = 21; end
    endcase
    if (!src[0] && x[25]) f = f - (64'd1 << w);
    return f;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pfx = 1'b0; m_val = '0;
    pv = 1'b0; preg = '0; psext = 1'b0;
  endtask

  // Drives one cycle, checks in_ready before the edge and outputs after it.
  task automatic drive_cycle(input logic v, input logic [25:0] imm, input logic [2:0] src,
                             input logic p, input logic fl, input logic rdy);
    logic        exp_rdy, acc;
    logic [63:0] b;
    in_valid = v; imm_in = imm; imm_src = src; prefix = p; flush = fl; out_ready = rdy;
    #1;
    exp_rdy = !fl && (!m_valid || rdy);
    n_cmp++;
    if (rdy32 !== exp_rdy || rdy64 !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready: got %b/%b expected %b", rdy32, rdy64, exp_rdy);
    end
    acc = v && exp_rdy;
    if (fl) begin
      m_valid = 1'b0; m_pfx = 1'b0; pv = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (acc && p) begin
        preg = c_field(imm)[15:0]; pv = 1'b1; psext = !src[0];
      end else if (acc) begin
        b = ref_ext(imm, src);
        if (pv) begin
          m_val = ((psext && preg[15]) ? 64'hFFFF_FFFF_0000_0000 : 64'd0)
                | (64'(preg) << 16) | (b & 64'hFFFF);
          m_pfx = 1'b1; pv = 1'b0;
        end else begin
          m_val = b; m_pfx = 1'b0;
        end
        m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ov32 !== m_valid || ov64 !== m_valid) begin
      n_err++;
      $display("FAIL out_valid: got %b/%b expected %b", ov32, ov64, m_valid);
    end
    n_cmp++;
    if (op32 !== m_pfx || op64 !== m_pfx) begin
      n_err++;
      $display("FAIL out_prefixed: got %b/%b expected %b", op32, op64, m_pfx);
    end
    if (m_valid) begin
      n_cmp++;
      if (io64 !== m_val || io32 !== m_val[31:0]) begin
        n_err++;
        $display("FAIL imm_out: got %h/%h expected %h", io32, io64, m_val);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; imm_in = '0; imm_src = '0;
    prefix = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #13;
    n_cmp++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || op32 !== 1'b0 || op64 !== 1'b0 ||
        io32 !== 32'd0 || io64 !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b/%b p=%b/%b imm=%h/%h expected all zero",
               ov32, ov64, op32, op64, io32, io64);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b/%b expected 1", rdy32, rdy64);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_formats();
    drive_cycle(1'b1, 26'h2000000, 3'b000, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'hFFFF8000) begin n_err++; $display("FAIL fmt_b_sext: got %h expected FFFF8000", io32); end
    drive_cycle(1'b1, 26'h2000000, 3'b001, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'h00008000) begin n_err++; $display("FAIL fmt_b_zext: got %h expected 00008000", io32); end
    drive_cycle(1'b1, 26'h3FFFFC0, 3'b100, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'hFFFFFFFC) begin n_err++; $display("FAIL fmt_e: got %h expected FFFFFFFC", io32); end
    drive_cycle(1'b1, 26'h0000020, 3'b110, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'h00000001) begin n_err++; $display("FAIL fmt_d: got %h expected 00000001", io32); end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_prefix_pair();
    drive_cycle(1'b1, 26'h0488500, 3'b011, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (ov32 !== 1'b0) begin n_err++; $display("FAIL prefix_no_output: got %b expected 0", ov32); end
    drive_cycle(1'b1, 26'h3FFFC00, 3'b001, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'h1234FFFF || op32 !== 1'b1) begin
      n_err++;
      $display("FAIL prefix_pair: got %h/%b expected 1234FFFF/1", io32, op32);
    end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 26'h2000000, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 26'h3FFFC00, 3'b001, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (io32 !== 32'hFFFF8000 || ov32 !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold: got %h/%b expected FFFF8000/1", io32, ov32);
      end
    end
    drive_cycle(1'b1, 26'h3FFFC00, 3'b001, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'h0000FFFF || ov32 !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got %h/%b expected 0000FFFF/1", io32, ov32);
    end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 26'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b1);
      if (ov32 === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 6) begin n_err++; $display("FAIL back_to_back: got %0d valid cycles expected 6", seen); end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 26'h0488500, 3'b011, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 26'h3FFFC00, 3'b001, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (ov32 !== 1'b0 || op32 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop: got %b/%b expected 0/0", ov32, op32);
    end
    drive_cycle(1'b1, 26'h0000400, 3'b001, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io32 !== 32'h00000001 || op32 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_after: got %h/%b expected 00000001/0", io32, op32);
    end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_xlen64();
    drive_cycle(1'b1, 26'h2000000, 3'b010, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 26'h0000400, 3'b000, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io64 !== 64'hFFFFFFFF80000001) begin
      n_err++;
      $display("FAIL x64_sext: got %h expected FFFFFFFF80000001", io64);
    end
    drive_cycle(1'b1, 26'h2000000, 3'b011, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 26'h0000400, 3'b000, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (io64 !== 64'h0000000080000001) begin
      n_err++;
      $display("FAIL x64_zext: got %h expected 0000000080000001", io64);
    end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 26'($urandom), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 7);
    end
    drive_cycle(1'b0, 26'h0, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 26'h0000020, 3'b110, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 26'h2000000, 3'b000, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 26'h2000000, 3'b000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || op32 !== 1'b0 || op64 !== 1'b0 ||
        io32 !== 32'd0 || io64 !== 64'd0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b/%b p=%b/%b imm=%h/%h expected all zero",
               ov32, ov64, op32, op64, io32, io64);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_ready: got %b/%b expected 1", rdy32, rdy64);
    end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 26'h0000400, 3'b001, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_prefix_pair();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_xlen64();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
